// File: rtl/div_unit.sv
// rtl/div_unit.sv - multi-cycle radix-2 restoring divider for DIV/DIVU (quotient->LO, remainder->HI)
// Optional macro DIV_ZERO_FASTPATH_EN: divide-by-zero finishes one cycle after accept.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             signed_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             annul_i,
    output logic             stall_o,
    output logic             ready_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
`ifdef DIV_ZERO_FASTPATH_EN
    logic             dz_q, dz_d;
`endif

    logic             accept;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic [WIDTH:0]   shifted, diff;
    logic             qbit;
    logic [WIDTH-1:0] res_hi, res_lo;

    assign accept = start_i & ~annul_i;
    assign abs_a  = (signed_i & a_i[WIDTH-1]) ? -a_i : a_i;
    assign abs_b  = (signed_i & b_i[WIDTH-1]) ? -b_i : b_i;

    // quo_q doubles as the dividend shift register: its MSB feeds the remainder each step
    assign shifted = {rem_q, quo_q[WIDTH-1]};
    assign diff    = shifted - {1'b0, dvs_q};
    assign qbit    = ~diff[WIDTH];

    always_comb begin
        res_lo = qneg_q ? -quo_q : quo_q;
        res_hi = rneg_q ? -rem_q : rem_q;
`ifdef DIV_ZERO_FASTPATH_EN
        if (dz_q) begin
            res_lo = '1;
            res_hi = quo_q;
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
`ifdef DIV_ZERO_FASTPATH_EN
        dz_d    = dz_q;
`endif
        stall_o = 1'b0;
        ready_o = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    stall_o = 1'b1;
                    rem_d   = '0;
                    quo_d   = abs_a;
                    dvs_d   = abs_b;
                    qneg_d  = signed_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
                    rneg_d  = signed_i & a_i[WIDTH-1];
                    cnt_d   = '0;
                    state_d = S_RUN;
`ifdef DIV_ZERO_FASTPATH_EN
                    dz_d    = 1'b0;
                    if (b_i == '0) begin
                        quo_d   = a_i;
                        dz_d    = 1'b1;
                        state_d = S_DONE;
                    end
`endif
                end
            end
            S_RUN: begin
                stall_o = 1'b1;
                if (annul_i) begin
                    state_d = S_IDLE;
                end else begin
                    rem_d = qbit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], qbit};
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                if (!annul_i) begin
                    ready_o = 1'b1;
                    hi_d    = res_hi;
                    lo_d    = res_lo;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // The result is visible in the DONE cycle itself so HI/LO can be written then
        hi_o = ready_o ? res_hi : hi_q;
        lo_o = ready_o ? res_lo : lo_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
`ifdef DIV_ZERO_FASTPATH_EN
            dz_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
`ifdef DIV_ZERO_FASTPATH_EN
            dz_q    <= dz_d;
`endif
        end
    end
endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - directed self-checking bench for div_unit
module tb_div_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_i = 1'b0;
    logic        signed_i = 1'b0;
    logic [31:0] a_i = '0;
    logic [31:0] b_i = '0;
    logic        annul_i = 1'b0;
    logic        stall_o, ready_o;
    logic [31:0] hi_o, lo_o;

    int n_checks = 0;
    int n_pass   = 0;

`ifdef DIV_ZERO_FASTPATH_EN
    localparam int DZ_LAT = 1;
    localparam int DZ_STALL = 1;
    localparam logic [31:0] NEG5_DZ_LO = 32'hFFFF_FFFF;
`else
    localparam int DZ_LAT = 33;
    localparam int DZ_STALL = 33;
    localparam logic [31:0] NEG5_DZ_LO = 32'h0000_0001;
`endif

    div_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .signed_i(signed_i),
        .a_i(a_i), .b_i(b_i), .annul_i(annul_i), .stall_o(stall_o),
        .ready_o(ready_o), .hi_o(hi_o), .lo_o(lo_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Issue at cycle 0; optional second start at ign_cyc must be ignored.
    task automatic run_div(input string tag, input logic sgn, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                           input int exp_lat, input int exp_stall, input int ign_cyc);
        int cyc;
        int stalls;
        bit got;
        cyc = 0; stalls = 0; got = 0;
        @(negedge clk);
        start_i = 1'b1; signed_i = sgn; a_i = a; b_i = b;
        #1 if (stall_o) stalls++;
        @(negedge clk);
        start_i = 1'b0; a_i = 32'h1234_5678; b_i = 32'h0000_0003;
        cyc = 1;
        while (cyc < 100 && !got) begin
            if (ready_o) begin
                got = 1;
                check({tag, " lat"}, 32'(cyc), 32'(exp_lat));
                check({tag, " lo"}, lo_o, exp_lo);
                check({tag, " hi"}, hi_o, exp_hi);
                check({tag, " stall_done"}, {31'd0, stall_o}, 32'd0);
            end else begin
                if (stall_o) stalls++;
                if (cyc == ign_cyc) start_i = 1'b1;
                @(negedge clk);
                start_i = 1'b0;
                cyc++;
            end
        end
        if (!got) check({tag, " timeout"}, 32'(cyc), 32'(exp_lat));
        check({tag, " stall_cycles"}, 32'(stalls), 32'(exp_stall));
        @(negedge clk);
        check({tag, " ready_pulse"}, {31'd0, ready_o}, 32'd0);
        check({tag, " hold_lo"}, lo_o, exp_lo);
    endtask

    initial begin
        int pulses;
        #1;
        check("rst stall", {31'd0, stall_o}, 32'd0);
        check("rst ready", {31'd0, ready_o}, 32'd0);
        check("rst hi", hi_o, 32'd0);
        check("rst lo", lo_o, 32'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33, 33, 0);
        run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33, 33, 0);
        run_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 33, 33, 0);
        run_div("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 33, 33, 0);
        run_div("div_m100_m7", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 32'hFFFF_FFFE, 33, 33, 0);
        run_div("divu_big", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 33, 33, 0);
        run_div("divu_ff_16", 1'b0, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 32'hF, 33, 33, 0);
        run_div("divu_9_0", 1'b0, 32'd9, 32'd0, 32'hFFFF_FFFF, 32'd9, DZ_LAT, DZ_STALL, 0);
        run_div("div_m5_0", 1'b1, 32'hFFFF_FFFB, 32'd0, NEG5_DZ_LO, 32'hFFFF_FFFB, DZ_LAT, DZ_STALL, 0);
        run_div("ign_start", 1'b0, 32'd1000, 32'd3, 32'd333, 32'd1, 33, 33, 3);

        // annul at RUN cycle 10: no result, outputs keep 333/1
        @(negedge clk);
        start_i = 1'b1; signed_i = 1'b0; a_i = 32'd50; b_i = 32'd5;
        @(negedge clk);
        start_i = 1'b0;
        repeat (9) @(negedge clk);
        annul_i = 1'b1;
        @(negedge clk);
        annul_i = 1'b0;
        check("annul stall", {31'd0, stall_o}, 32'd0);
        pulses = 0;
        repeat (40) begin
            if (ready_o) pulses++;
            @(negedge clk);
        end
        check("annul pulses", 32'(pulses), 32'd0);
        check("annul lo", lo_o, 32'd333);
        check("annul hi", hi_o, 32'd1);
        run_div("after_annul", 1'b0, 32'd50, 32'd6, 32'd8, 32'd2, 33, 33, 0);

        // start together with annul in IDLE is refused
        @(negedge clk);
        start_i = 1'b1; annul_i = 1'b1; a_i = 32'd10; b_i = 32'd2;
        #1 check("annul_start stall", {31'd0, stall_o}, 32'd0);
        @(negedge clk);
        start_i = 1'b0; annul_i = 1'b0;
        check("annul_start idle", {31'd0, stall_o}, 32'd0);
        repeat (35) @(negedge clk);
        check("annul_start lo", lo_o, 32'd8);

        // async reset mid-RUN
        @(negedge clk);
        start_i = 1'b1; a_i = 32'd1000; b_i = 32'd3;
        @(negedge clk);
        start_i = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst stall", {31'd0, stall_o}, 32'd0);
        check("arst ready", {31'd0, ready_o}, 32'd0);
        check("arst hi", hi_o, 32'd0);
        check("arst lo", lo_o, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        repeat (40) begin
            if (ready_o) pulses++;
            @(negedge clk);
        end
        check("arst pulses", 32'(pulses), 32'd0);
        run_div("after_rst", 1'b0, 32'd1000, 32'd3, 32'd333, 32'd1, 33, 33, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
